// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - video mode constants, per-pixel timing bundle and decode helper
package vga_timing_pkg;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } mode_t;

  localparam mode_t MODE_640X480 = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                     v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                                     hs_pol: 1'b0, vs_pol: 1'b0};
  localparam mode_t MODE_800X600 = '{h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
                                     v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23,
                                     hs_pol: 1'b1, vs_pol: 1'b1};
  localparam mode_t MODE_1280X720 = '{h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
                                      v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20,
                                      hs_pol: 1'b1, vs_pol: 1'b1};

  // Coordinate fields are sized for the largest supported mode (1650 x 750 totals).
  localparam int BUNDLE_XW = 12;
  localparam int BUNDLE_YW = 12;

  // hs/vs are "asserted" flags; polarity is applied only at the output pins so
  // that a cleared pipeline stage reads as sync-inactive.
  typedef struct packed {
    logic                 hs;
    logic                 vs;
    logic                 de;
    logic [BUNDLE_XW-1:0] x;
    logic [BUNDLE_YW-1:0] y;
    logic                 line;
    logic                 frame;
    logic                 anim;
  } timing_t;

  function automatic logic in_window(int pos, int lo, int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - strobe/restart inputs and raster timing outputs
interface vga_timing_gen_if #(
  parameter int XW  = 10,
  parameter int YW  = 10,
  parameter int FCW = 16
);
  logic           i_pix_stb;
  logic           i_restart;
  logic           o_hs;
  logic           o_vs;
  logic           o_de;
  logic [XW-1:0]  o_x;
  logic [YW-1:0]  o_y;
  logic           o_line_start;
  logic           o_frame_start;
  logic           o_animate;
  logic [FCW-1:0] o_frame_cnt;

  modport master (
    output i_pix_stb, i_restart,
    input  o_hs, o_vs, o_de, o_x, o_y, o_line_start, o_frame_start, o_animate, o_frame_cnt
  );

  modport slave (
    input  i_pix_stb, i_restart,
    output o_hs, o_vs, o_de, o_x, o_y, o_line_start, o_frame_start, o_animate, o_frame_cnt
  );
endinterface

// File: rtl/vga_pipe_delay.sv
// rtl/vga_pipe_delay.sv - strobe-enabled register chain of configurable depth and width
module vga_pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  // Shift the whole chain by one position on each enable, otherwise hold
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    if (i_en) begin
      stage_d[0] = i_d;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  // Chain registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with delayed outputs
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int   H_ACTIVE = MODE_640X480.h_active,
  parameter int   H_FP     = MODE_640X480.h_fp,
  parameter int   H_SYNC   = MODE_640X480.h_sync,
  parameter int   H_BP     = MODE_640X480.h_bp,
  parameter int   V_ACTIVE = MODE_640X480.v_active,
  parameter int   V_FP     = MODE_640X480.v_fp,
  parameter int   V_SYNC   = MODE_640X480.v_sync,
  parameter int   V_BP     = MODE_640X480.v_bp,
  parameter logic HS_POL   = MODE_640X480.hs_pol,
  parameter logic VS_POL   = MODE_640X480.vs_pol,
  parameter int   PIPE     = 1,
  parameter int   FCW      = 16
) (
  input logic              i_clk,
  input logic              i_rst_n,
  vga_timing_gen_if.slave  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  logic [XW-1:0]  h_q, h_d;
  logic [YW-1:0]  v_q, v_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           stb_q, stb_d;
  timing_t        stage0;
  timing_t        last;
  logic           unused_bits;

  // Raster position and frame count; restart beats the strobe, including at wrap
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    stb_d       = bus.i_pix_stb;
    if (bus.i_restart) begin
      h_d         = '0;
      v_d         = '0;
      frame_cnt_d = '0;
    end else if (bus.i_pix_stb) begin
      if (h_q == XW'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == YW'(V_TOTAL - 1)) begin
          v_d         = '0;
          frame_cnt_d = frame_cnt_q + FCW'(1);
        end else begin
          v_d = v_q + YW'(1);
        end
      end else begin
        h_d = h_q + XW'(1);
      end
    end
  end

  // Counter and strobe-history registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      stb_q       <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      stb_q       <= stb_d;
    end
  end

  // Stage 0: decode the current raster position into the timing bundle
  always_comb begin
    stage0    = '0;
    stage0.hs = in_window(int'(h_q), H_ACTIVE + H_FP, H_SYNC);
    stage0.vs = in_window(int'(v_q), V_ACTIVE + V_FP, V_SYNC);
    stage0.de = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    if (stage0.de) begin
      stage0.x = BUNDLE_XW'(h_q);
      stage0.y = BUNDLE_YW'(v_q);
    end
    stage0.line  = (h_q == '0);
    stage0.frame = (h_q == '0) && (v_q == '0);
    stage0.anim  = (h_q == XW'(H_ACTIVE)) && (v_q == YW'(V_ACTIVE - 1));
  end

  vga_pipe_delay #(
    .W     ($bits(timing_t)),
    .DEPTH (PIPE)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (bus.i_pix_stb),
    .i_d     (stage0),
    .o_q     (last)
  );

  // Levels hold between strobes; pulses are gated by the previous-clock strobe
  // so they last one clock regardless of the strobe period.
  assign bus.o_hs          = last.hs ? HS_POL : ~HS_POL;
  assign bus.o_vs          = last.vs ? VS_POL : ~VS_POL;
  assign bus.o_de          = last.de;
  assign bus.o_x           = last.x[XW-1:0];
  assign bus.o_y           = last.y[YW-1:0];
  assign bus.o_line_start  = last.line & stb_q;
  assign bus.o_frame_start = last.frame & stb_q;
  assign bus.o_animate     = last.anim & stb_q;
  assign bus.o_frame_cnt   = frame_cnt_q;

  assign unused_bits = ^{last.x, last.y};

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] x;
    logic [15:0] y;
    logic        line;
    logic        frame;
    logic        anim;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stb = 1'b0;
  logic restart = 1'b0;
  int   checks = 0;
  int   passes = 0;

  int hs_low_cnt, first_hs_h, de_cnt, line_cnt, c_line0, c_line1, s_frm0, s_frm1;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(10), .YW(10), .FCW(16)) ifa ();
  vga_timing_gen_if #(.XW(10), .YW(10), .FCW(16)) ifb ();
  vga_timing_gen_if #(.XW(11), .YW(10), .FCW(16)) ifc ();
  vga_timing_gen_if #(.XW(4),  .YW(3),  .FCW(2))  ifs ();

  assign ifa.i_pix_stb = stb;
  assign ifb.i_pix_stb = stb;
  assign ifc.i_pix_stb = stb;
  assign ifs.i_pix_stb = stb;
  assign ifa.i_restart = restart;
  assign ifb.i_restart = restart;
  assign ifc.i_restart = restart;
  assign ifs.i_restart = restart;

  vga_timing_gen #(.PIPE(1)) u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  vga_timing_gen #(.PIPE(3)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));
  vga_timing_gen #(
    .H_ACTIVE(MODE_800X600.h_active), .H_FP(MODE_800X600.h_fp),
    .H_SYNC(MODE_800X600.h_sync), .H_BP(MODE_800X600.h_bp),
    .V_ACTIVE(MODE_800X600.v_active), .V_FP(MODE_800X600.v_fp),
    .V_SYNC(MODE_800X600.v_sync), .V_BP(MODE_800X600.v_bp),
    .HS_POL(MODE_800X600.hs_pol), .VS_POL(MODE_800X600.vs_pol), .PIPE(1)
  ) u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc));
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIPE(2), .FCW(2)
  ) u_s (.i_clk(clk), .i_rst_n(rst_n), .bus(ifs));

  // Expected outputs after s strobes since reset; hs/vs as asserted flags
  function automatic obs_t model(int ha, int hf, int hsw, int hb, int va, int vf, int vsw,
                                 int vb, int pipe, int fcw, int s, bit pulse);
    obs_t e;
    int ht, vt, p, h, v;
    e  = '0;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    e.fc = 16'((s / (ht * vt)) % (1 << fcw));
    if (s >= pipe) begin
      p = s - pipe;
      h = p % ht;
      v = (p / ht) % vt;
      e.hs = (h >= ha + hf) && (h < ha + hf + hsw);
      e.vs = (v >= va + vf) && (v < va + vf + vsw);
      e.de = (h < ha) && (v < va);
      if (e.de) begin
        e.x = 16'(h);
        e.y = 16'(v);
      end
      e.line  = pulse && (h == 0);
      e.frame = pulse && (h == 0) && (v == 0);
      e.anim  = pulse && (h == ha) && (v == va - 1);
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; stb = 1'b0; restart = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_trace(input int ncyc, input int stride);
    obs_t e [4];
    obs_t a [4];
    obs_t bad_a [4];
    obs_t bad_e [4];
    int   err [4];
    int   s;
    do_reset();
    s = 0;
    hs_low_cnt = 0; first_hs_h = -1; de_cnt = 0; line_cnt = 0;
    c_line0 = -1; c_line1 = -1; s_frm0 = -1; s_frm1 = -1;
    for (int k = 0; k < 4; k++) begin err[k] = 0; bad_a[k] = '0; bad_e[k] = '0; end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      stb = (cyc % stride == 0);
      @(posedge clk);
      if (stb) s++;
      #1;
      e[0] = model(640, 16, 96, 48, 480, 10, 2, 33, 1, 16, s, stb);
      e[1] = model(640, 16, 96, 48, 480, 10, 2, 33, 3, 16, s, stb);
      e[2] = model(800, 40, 128, 88, 600, 1, 4, 23, 1, 16, s, stb);
      e[3] = model(8, 2, 3, 2, 4, 1, 2, 1, 2, 2, s, stb);
      a[0] = '{hs: ifa.o_hs == 1'b0, vs: ifa.o_vs == 1'b0, de: ifa.o_de, x: 16'(ifa.o_x),
               y: 16'(ifa.o_y), line: ifa.o_line_start, frame: ifa.o_frame_start,
               anim: ifa.o_animate, fc: 16'(ifa.o_frame_cnt)};
      a[1] = '{hs: ifb.o_hs == 1'b0, vs: ifb.o_vs == 1'b0, de: ifb.o_de, x: 16'(ifb.o_x),
               y: 16'(ifb.o_y), line: ifb.o_line_start, frame: ifb.o_frame_start,
               anim: ifb.o_animate, fc: 16'(ifb.o_frame_cnt)};
      a[2] = '{hs: ifc.o_hs == 1'b1, vs: ifc.o_vs == 1'b1, de: ifc.o_de, x: 16'(ifc.o_x),
               y: 16'(ifc.o_y), line: ifc.o_line_start, frame: ifc.o_frame_start,
               anim: ifc.o_animate, fc: 16'(ifc.o_frame_cnt)};
      a[3] = '{hs: ifs.o_hs == 1'b0, vs: ifs.o_vs == 1'b1, de: ifs.o_de, x: 16'(ifs.o_x),
               y: 16'(ifs.o_y), line: ifs.o_line_start, frame: ifs.o_frame_start,
               anim: ifs.o_animate, fc: 16'(ifs.o_frame_cnt)};
      for (int k = 0; k < 4; k++) begin
        if (a[k] !== e[k]) begin
          if (err[k] == 0) begin bad_a[k] = a[k]; bad_e[k] = e[k]; end
          err[k]++;
        end
      end
      if (s >= 1 && s <= 800 && ifa.o_hs == 1'b0) hs_low_cnt++;
      if (first_hs_h < 0 && ifa.o_hs == 1'b0) first_hs_h = s - 1;
      if (stb && s >= 1 && s <= 800 && ifa.o_de) de_cnt++;
      if (ifa.o_line_start) line_cnt++;
      if (ifc.o_line_start) begin
        if (c_line0 < 0) c_line0 = s; else if (c_line1 < 0) c_line1 = s;
      end
      if (ifs.o_frame_start) begin
        if (s_frm0 < 0) s_frm0 = s; else if (s_frm1 < 0) s_frm1 = s;
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (err[k] !== 0)
        $display("FAIL trace_dut%0d_stride%0d: %0d bad cycles, first got %h required %h",
                 k, stride, err[k], bad_a[k], bad_e[k]);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stb = 1'b1; restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifa.o_hs !== 1'b1) $display("FAIL reset_hs_lowpol: got %b required 1", ifa.o_hs); else passes++;
    checks++; if (ifa.o_vs !== 1'b1) $display("FAIL reset_vs_lowpol: got %b required 1", ifa.o_vs); else passes++;
    checks++; if ({ifa.o_de, ifa.o_x, ifa.o_y} !== '0) $display("FAIL reset_de_xy: got %b/%0d/%0d required 0", ifa.o_de, ifa.o_x, ifa.o_y); else passes++;
    checks++; if ({ifa.o_line_start, ifa.o_frame_start, ifa.o_animate} !== 3'b000) $display("FAIL reset_pulses: got %b required 000", {ifa.o_line_start, ifa.o_frame_start, ifa.o_animate}); else passes++;
    checks++; if (ifa.o_frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d required 0", ifa.o_frame_cnt); else passes++;
    checks++; if ({ifc.o_hs, ifc.o_vs} !== 2'b00) $display("FAIL reset_sync_highpol: got %b required 00", {ifc.o_hs, ifc.o_vs}); else passes++;
    checks++; if ({ifs.o_hs, ifs.o_vs} !== 2'b10) $display("FAIL reset_sync_mixedpol: got %b required 10", {ifs.o_hs, ifs.o_vs}); else passes++;
  endtask

  task automatic test_one_pixel_per_clock();
    run_trace(1700, 1);
    checks++; if (hs_low_cnt !== 96) $display("FAIL hs_low_width: got %0d required 96", hs_low_cnt); else passes++;
    checks++; if (first_hs_h !== 656) $display("FAIL hs_start_h: got %0d required 656", first_hs_h); else passes++;
    checks++; if (line_cnt !== 3) $display("FAIL line_pulses_800: got %0d required 3", line_cnt); else passes++;
    checks++; if (c_line1 - c_line0 !== 1056) $display("FAIL line_period_800x600: got %0d required 1056", c_line1 - c_line0); else passes++;
    checks++; if (s_frm1 - s_frm0 !== 120) $display("FAIL frame_period_small: got %0d required 120", s_frm1 - s_frm0); else passes++;
  endtask

  task automatic test_slow_strobe();
    run_trace(3400, 4);
    checks++; if (de_cnt !== 640) $display("FAIL de_strobes_line0: got %0d required 640", de_cnt); else passes++;
    checks++; if (line_cnt !== 2) $display("FAIL line_pulse_clocks: got %0d required 2", line_cnt); else passes++;
  endtask

  task automatic test_restart();
    int a_frame_j1, s_frame_j2, s_frames, s_anims, s_anim55;
    do_reset();
    stb = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    checks++; if (ifs.o_frame_cnt !== 2'd1) $display("FAIL fc_before_restart: got %0d required 1", ifs.o_frame_cnt); else passes++;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    checks++; if (ifs.o_frame_cnt !== 2'd0) $display("FAIL fc_after_restart: got %0d required 0", ifs.o_frame_cnt); else passes++;
    a_frame_j1 = 0; s_frame_j2 = 0; s_frames = 0; s_anims = 0; s_anim55 = 0;
    for (int j = 1; j <= 55; j++) begin
      @(posedge clk); #1;
      if (j == 1) a_frame_j1 = int'(ifa.o_frame_start);
      if (j == 2) s_frame_j2 = int'(ifs.o_frame_start);
      if (j <= 54) begin
        s_frames += int'(ifs.o_frame_start);
        s_anims  += int'(ifs.o_animate);
      end
      if (j == 55) s_anim55 = int'(ifs.o_animate);
    end
    checks++; if (a_frame_j1 !== 1) $display("FAIL restart_frame_pipe1: got %0d required 1", a_frame_j1); else passes++;
    checks++; if (s_frame_j2 !== 1) $display("FAIL restart_frame_pipe2: got %0d required 1", s_frame_j2); else passes++;
    checks++; if (s_frames !== 1) $display("FAIL restart_frame_count: got %0d required 1", s_frames); else passes++;
    checks++; if (s_anims !== 0) $display("FAIL restart_no_anim: got %0d required 0", s_anims); else passes++;
    checks++; if (s_anim55 !== 1) $display("FAIL restart_next_anim: got %0d required 1", s_anim55); else passes++;

    do_reset();
    stb = 1'b1;
    repeat (119) @(posedge clk);
    #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    checks++; if (ifs.o_frame_cnt !== 2'd0) $display("FAIL restart_at_wrap: got %0d required 0", ifs.o_frame_cnt); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    stb = 1'b1;
    repeat (130) @(posedge clk);
    #1;
    checks++; if ({ifa.o_de, ifa.o_x} !== {1'b1, 10'd129}) $display("FAIL pre_drop_pos: got %b/%0d required 1/129", ifa.o_de, ifa.o_x); else passes++;
    checks++; if (ifs.o_frame_cnt !== 2'd1) $display("FAIL pre_drop_fc: got %0d required 1", ifs.o_frame_cnt); else passes++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({ifa.o_hs, ifa.o_de, ifa.o_x, ifa.o_line_start} !== {1'b1, 1'b0, 10'd0, 1'b0}) $display("FAIL async_reset_a: got hs=%b de=%b x=%0d line=%b required 1/0/0/0", ifa.o_hs, ifa.o_de, ifa.o_x, ifa.o_line_start); else passes++;
    checks++; if ({ifc.o_hs, ifs.o_frame_cnt} !== {1'b0, 2'd0}) $display("FAIL async_reset_c_s: got hs=%b fc=%0d required 0/0", ifc.o_hs, ifs.o_frame_cnt); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ifa.o_de, ifa.o_x, ifa.o_y, ifa.o_frame_start} !== {1'b1, 10'd0, 10'd0, 1'b1}) $display("FAIL post_reset_origin: got de=%b x=%0d y=%0d frame=%b required 1/0/0/1", ifa.o_de, ifa.o_x, ifa.o_y, ifa.o_frame_start); else passes++;
  endtask

  initial begin
    test_reset();
    test_one_pixel_per_clock();
    test_slow_strobe();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
